vga_layer_compositor: RTL
=========================

Name: vga_layer_compositor

Overview:
Parametrised successor to the single-text/single-graphics screen top. It integrates the VGA timing chain (pixel-tick divider, h/v counters, syncs) with an N-layer priority compositor, per-layer enable/blink masking and a frame-based blink generator. All outputs (RGB, hsync, vsync) are registered on the pixel tick so they stay mutually aligned. Layer generators (text, figures, cursor) are driven from pixel_x/pixel_y and return on/colour combinationally within the same pixel.

Parameters:
NUM_LAYERS, 4, number of compositing layers; index 0 has highest priority
COLOR_W, 12, bits per pixel (4:4:4)
TICK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 2
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BACK, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FRONT, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BACK, 33, vertical back porch
SYNC_ACTIVE, 0, sync pulse level (0 = active-low)
BLINK_FRAMES, 30, frames per blink half-period

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
layer_on  in  NUM_LAYERS  per-layer pixel-present flag for current pixel_x/pixel_y
layer_rgb  in  NUM_LAYERS*COLOR_W  per-layer colour; layer i occupies bits [i*COLOR_W +: COLOR_W]
layer_enable  in  NUM_LAYERS  static layer enable (1 = shown)
blink_mask  in  NUM_LAYERS  1 = layer is hidden during the blink-off phase
bg_rgb  in  COLOR_W  background colour inside the visible area
pixel_x  out  10  current horizontal counter (0..H_TOTAL-1)
pixel_y  out  10  current vertical counter (0..V_TOTAL-1)
pixel_tick  out  1  one-clock pulse per pixel
video_on  out  1  combinational: pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
frame_start  out  1  one-clock pulse at frame wrap
blink_phase  out  1  current blink phase (1 = hidden)
hsync  out  1  registered horizontal sync
vsync  out  1  registered vertical sync
RGB  out  COLOR_W  registered pixel colour

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Reset (reset=0, async): tick counter, h, v, frame counter = 0; blink_phase=0; RGB=0; hsync=vsync=~SYNC_ACTIVE; pixel_tick=frame_start=0.
- Tick divider: counter 0..TICK_DIV-1, wraps. pixel_tick=1 when counter==TICK_DIV-1 (registered-state decode). First tick is TICK_DIV clocks after reset release.
- On pixel_tick: h<=h+1; at h==H_TOTAL-1, h<=0 and v advances; at v==V_TOTAL-1 with h wrap, v<=0. Counters are stable between ticks.
- Sync decode: hsync_comb = SYNC_ACTIVE when H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC (656..751), else inverse. vsync_comb is analogous on v (490..491).
- Compositor (combinational per pixel): eff[i] = layer_on[i] & layer_enable[i] & ~(blink_mask[i] & blink_phase). Winner = lowest i with eff[i]=1 -> layer_rgb slice; none -> bg_rgb; ~video_on -> 0 (overrides everything).
- Output stage: on pixel_tick, RGB<=next, hsync<=hsync_comb, vsync<=vsync_comb. Latency: one pixel (TICK_DIV clocks); RGB and syncs stay aligned. Outputs hold between ticks.
- frame_start = pixel_tick & h==H_TOTAL-1 & v==V_TOTAL-1.
- Blink: on frame_start the frame counter increments; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles. Period = 2*BLINK_FRAMES frames.
- Input changes between ticks are ignored; only values present in the tick cycle are sampled.
- Reset mid-frame: immediate async return to reset values. Scan restarts at (0,0) and the blink phase restarts at 0.

Test Plan:
- Reset release: RGB=0, hsync=vsync=1, pixel_x=pixel_y=0; first pixel_tick exactly 4 clocks after reset rises; pixel_tick then repeats every 4 clocks.
- Line/frame timing: count ticks -> hsync low for 96 ticks starting one tick after h=656; line = 800 ticks; vsync low for 2 lines (v=490..491); frame = 420000 ticks, frame_start single-clock pulse at wrap.
- Priority: at (100,100), layer_on=4'b0110, rgb1=12'hF00, rgb2=12'h0F0 -> RGB=12'hF00 one tick later; clear layer_enable[1] -> 12'h0F0; layer_on=0 -> bg_rgb (12'h00F).
- Blanking: layer_on=4'b1111 with pixel_x=700 -> RGB=0 regardless of bg_rgb and layers.
- Blink: blink_mask[0]=1, layer 0 on with 12'hFFF over layer 1 12'h0F0 -> frames 0..29 show 12'hFFF, frames 30..59 show 12'h0F0, frame 60 back to 12'hFFF.
- Mid-frame reset at v=200, h=300, blink_phase=1 -> all outputs return to reset values asynchronously (same clock); after release, scan restarts at (0,0) and blink_phase=0.

Source files
------------

// File: rtl/vga_layer_compositor_if.sv
// Bundle between the compositor and its layer generators / display side:
// per-layer pixel inputs plus the scan position, syncs and registered colour.
interface vga_layer_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 12
);
  logic [NUM_LAYERS-1:0]         layer_on;
  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
  logic [NUM_LAYERS-1:0]         layer_enable;
  logic [NUM_LAYERS-1:0]         blink_mask;
  logic [COLOR_W-1:0]            bg_rgb;
  logic [9:0]                    pixel_x;
  logic [9:0]                    pixel_y;
  logic                          pixel_tick;
  logic                          video_on;
  logic                          frame_start;
  logic                          blink_phase;
  logic                          hsync;
  logic                          vsync;
  logic [COLOR_W-1:0]            RGB;

  // Layer generators / display side
  modport master (
    output layer_on, layer_rgb, layer_enable, blink_mask, bg_rgb,
    input  pixel_x, pixel_y, pixel_tick, video_on, frame_start, blink_phase,
           hsync, vsync, RGB
  );

  // Compositor side
  modport slave (
    input  layer_on, layer_rgb, layer_enable, blink_mask, bg_rgb,
    output pixel_x, pixel_y, pixel_tick, video_on, frame_start, blink_phase,
           hsync, vsync, RGB
  );
endinterface

// File: rtl/vga_layer_compositor.sv
// VGA timing chain plus an N-layer priority compositor with enable/blink masking.
// RGB, hsync and vsync are all registered on the same pixel tick so they stay aligned.
module vga_layer_compositor #(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_W      = 12,
  parameter int TICK_DIV     = 4,
  parameter int H_ACTIVE     = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int SYNC_ACTIVE  = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   clock,
  input  logic                   reset,
  vga_layer_compositor_if.slave  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic SYNC_ON = (SYNC_ACTIVE != 0);

  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [9:0]            h_q, h_d;
  logic [9:0]            v_q, v_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  blink_q, blink_d;
  logic [COLOR_W-1:0]    rgb_q, rgb_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;

  logic                  pixel_tick;
  logic                  h_last;
  logic                  v_last;
  logic                  frame_start;
  logic                  video_on;
  logic                  hsync_comb;
  logic                  vsync_comb;
  logic [NUM_LAYERS-1:0] eff;
  logic [COLOR_W-1:0]    pix_next;

  // Tick is decoded from the registered divider state, so it is glitch-free.
  assign pixel_tick  = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign h_last      = (h_q == 10'(H_TOTAL - 1));
  assign v_last      = (v_q == 10'(V_TOTAL - 1));
  assign frame_start = pixel_tick & h_last & v_last;
  assign video_on    = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));

  assign hsync_comb = ((h_q >= 10'(H_ACTIVE + H_FRONT)) &&
                       (h_q <  10'(H_ACTIVE + H_FRONT + H_SYNC))) ? SYNC_ON : ~SYNC_ON;
  assign vsync_comb = ((v_q >= 10'(V_ACTIVE + V_FRONT)) &&
                       (v_q <  10'(V_ACTIVE + V_FRONT + V_SYNC))) ? SYNC_ON : ~SYNC_ON;

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_eff
      assign eff[gi] = bus.layer_on[gi] & bus.layer_enable[gi] &
                       ~(bus.blink_mask[gi] & blink_q);
    end
  endgenerate

  // Scan from the lowest-priority layer upward so layer 0 is written last and wins.
  always_comb begin
    pix_next = bus.bg_rgb;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff[i]) begin
        pix_next = bus.layer_rgb[i*COLOR_W +: COLOR_W];
      end
    end
    if (!video_on) begin
      pix_next = '0;
    end
  end

  always_comb begin
    tick_cnt_d  = pixel_tick ? '0 : tick_cnt_q + TW'(1);
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    rgb_d       = rgb_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;

    if (pixel_tick) begin
      rgb_d   = pix_next;
      hsync_d = hsync_comb;
      vsync_d = vsync_comb;
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    if (frame_start) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt_q  <= '0;
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
      rgb_q       <= '0;
      hsync_q     <= ~SYNC_ON;
      vsync_q     <= ~SYNC_ON;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign bus.pixel_x     = h_q;
  assign bus.pixel_y     = v_q;
  assign bus.pixel_tick  = pixel_tick;
  assign bus.video_on    = video_on;
  assign bus.frame_start = frame_start;
  assign bus.blink_phase = blink_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.RGB         = rgb_q;

endmodule
